// File: rtl/memory_sram_core_512x8.sv
// Simple-dual-port 512x8 RAM with registered read and a built-in clear sequencer.
// Define MEMORY_SRAM_READ_BYPASS_EN for write-first collisions (read-first otherwise).
module memory_sram_core_512x8 #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
) (
   input  logic              memory_clk,
   input  logic              memory_rst_n,
   input  logic [ADDR_W-1:0] memory_waddr,
   input  logic [ADDR_W-1:0] memory_raddr,
   input  logic [DATA_W-1:0] memory_data_in,
   input  logic              memory_wen,
   input  logic              memory_ren,
   input  logic              memory_clr,
   output logic              memory_busy,
   output logic [DATA_W-1:0] memory_data_out
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic {
      S_CLEAR,
      S_IDLE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = memory_waddr;
      mem_wdata = memory_data_in;
      rd_en     = 1'b0;
      unique case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_wdata = '0;
            cnt_d     = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_IDLE: begin
            mem_we = memory_wen;
            rd_en  = memory_ren;
            cnt_d  = '0;
            if (memory_clr) state_d = S_CLEAR;
         end
         default: state_d = S_CLEAR;
      endcase
   end

`ifdef MEMORY_SRAM_READ_BYPASS_EN
   logic collision;
   assign collision = memory_wen && memory_ren && (memory_waddr == memory_raddr);
   assign rd_data   = collision ? memory_data_in : mem_q[memory_raddr];
`else
   // Read-first falls out naturally: the array update lands after this edge's read.
   assign rd_data = mem_q[memory_raddr];
`endif

   always_comb begin
      data_out_d = data_out_q;
      if (rd_en) data_out_d = rd_data;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge memory_clk or negedge memory_rst_n) begin
      if (!memory_rst_n) begin
         state_q    <= S_CLEAR;
         cnt_q      <= '0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
      end
   end

   // NOTE: the array has no reset; it maps onto RAM macros and is zeroed by the clear sequence instead.
   always_ff @(posedge memory_clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign memory_busy     = (state_q == S_CLEAR);
   assign memory_data_out = data_out_q;

endmodule

// File: tb/tb_memory_sram_core_512x8.sv
// Directed bench for memory_sram_core_512x8: vector table for single-cycle accesses,
// hand-written sequences for reset, clear request and reset-during-clear.
module tb_memory_sram_core_512x8;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 512;
   localparam int BOUND  = 600;

`ifdef MEMORY_SRAM_READ_BYPASS_EN
   localparam logic [7:0] COLL_EXP = 8'h99;
`else
   localparam logic [7:0] COLL_EXP = 8'h11;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] waddr = '0;
   logic [ADDR_W-1:0] raddr = '0;
   logic [DATA_W-1:0] din = '0;
   logic              wen = 1'b0;
   logic              ren = 1'b0;
   logic              clr = 1'b0;
   logic              busy;
   logic [DATA_W-1:0] dout;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   memory_sram_core_512x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .memory_clk      (clk),
      .memory_rst_n    (rst_n),
      .memory_waddr    (waddr),
      .memory_raddr    (raddr),
      .memory_data_in  (din),
      .memory_wen      (wen),
      .memory_ren      (ren),
      .memory_clr      (clr),
      .memory_busy     (busy),
      .memory_data_out (dout)
   );

   typedef struct {
      string      name;
      logic       wen;
      logic       ren;
      logic [8:0] waddr;
      logic [8:0] raddr;
      logic [7:0] din;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(string name, logic w, logic r, logic [8:0] wa, logic [8:0] ra,
                               logic [7:0] d, logic [7:0] e);
      vec_t v;
      v.name = name; v.wen = w; v.ren = r; v.waddr = wa; v.raddr = ra; v.din = d; v.exp_dout = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wen = 1'b0; ren = 1'b0; clr = 1'b0;
   endtask

   // Ticks until busy drops; returns the number of edges taken (BOUND if it never drops).
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < BOUND) begin
         tick();
         n++;
      end
   endtask

   task automatic write_word(input logic [8:0] a, input logic [7:0] d);
      wen = 1'b1; ren = 1'b0; waddr = a; din = d;
      tick();
      wen = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [8:0] a, input logic [7:0] e);
      wen = 1'b0; ren = 1'b1; raddr = a;
      tick();
      ren = 1'b0;
      check(name, dout, e);
   endtask

   initial begin
      int n;
      logic [7:0] held;

      tbl[0]  = mk("t2_wr_000",      1, 0, 9'h000, 9'h000, 8'hA5, 8'h00);
      tbl[1]  = mk("t2_wr_1ff",      1, 0, 9'h1FF, 9'h000, 8'h3C, 8'h00);
      tbl[2]  = mk("t2_rd_1ff",      0, 1, 9'h000, 9'h1FF, 8'h00, 8'h3C);
      tbl[3]  = mk("t2_rd_000",      0, 1, 9'h000, 9'h000, 8'h00, 8'hA5);
      tbl[4]  = mk("t2_hold_1",      0, 0, 9'h000, 9'h1FF, 8'h00, 8'hA5);
      tbl[5]  = mk("t2_hold_2",      0, 0, 9'h000, 9'h1FF, 8'h00, 8'hA5);
      tbl[6]  = mk("t2_hold_3",      0, 0, 9'h000, 9'h1FF, 8'h00, 8'hA5);
      tbl[7]  = mk("t2_hold_4",      0, 0, 9'h000, 9'h1FF, 8'h00, 8'hA5);
      tbl[8]  = mk("t2_hold_5",      0, 0, 9'h000, 9'h1FF, 8'h00, 8'hA5);
      tbl[9]  = mk("t3_preload",     1, 0, 9'h080, 9'h000, 8'h11, 8'hA5);
      tbl[10] = mk("t3_collision",   1, 1, 9'h080, 9'h080, 8'h99, COLL_EXP);
      tbl[11] = mk("t3_reread",      0, 1, 9'h000, 9'h080, 8'h00, 8'h99);
      tbl[12] = mk("wr_rd_distinct", 1, 1, 9'h100, 9'h1FF, 8'h77, 8'h3C);
      tbl[13] = mk("rd_100",         0, 1, 9'h000, 9'h100, 8'h00, 8'h77);
      tbl[14] = mk("rd_0ff_clear",   0, 1, 9'h000, 9'h0FF, 8'h00, 8'h00);
      tbl[15] = mk("rd_000_again",   0, 1, 9'h000, 9'h000, 8'h00, 8'hA5);

      // T1: reset and power-up clear
      repeat (3) tick();
      check("t1_rst_dout", dout, 8'h00);
      check("t1_rst_busy", busy, 1'b1);
      rst_n = 1'b1;
      #1;
      check("t1_rel_busy", busy, 1'b1);
      count_busy(n);
      check("t1_busy_len", n, DEPTH);
      check("t1_dout_after", dout, 8'h00);
      for (int i = 0; i < DEPTH; i++) read_check("t1_rd_zero", 9'(i), 8'h00);

      // T2/T3: single-cycle accesses from the vector table
      for (int i = 0; i < 16; i++) begin
         wen = tbl[i].wen; ren = tbl[i].ren; waddr = tbl[i].waddr;
         raddr = tbl[i].raddr; din = tbl[i].din;
         tick();
         check(tbl[i].name, dout, tbl[i].exp_dout);
         check({tbl[i].name, "_busy"}, busy, 1'b0);
      end
      idle_inputs();

      // T4: clear request; accesses during busy are dropped and data_out holds
      for (int i = 0; i < 8; i++) write_word(9'(i), 8'hFF);
      read_check("t4_rd_7_ff", 9'h007, 8'hFF);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t4_busy_start", busy, 1'b1);
      held = dout;
      wen = 1'b1; waddr = 9'h003; din = 8'h55; ren = 1'b1; raddr = 9'h005;
      count_busy(n);
      idle_inputs();
      check("t4_busy_len", n, DEPTH);
      check("t4_dout_held", dout, held);
      for (int i = 0; i < 8; i++) read_check("t4_rd_cleared", 9'(i), 8'h00);

      // T6: clr while busy does not restart the sequence
      write_word(9'h010, 8'hC3);
      read_check("t6_rd_c3", 9'h010, 8'hC3);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (100) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      count_busy(n);
      check("t6_busy_len", n + 101, DEPTH);
      check("t6_dout_held", dout, 8'hC3);

      // T5: reset at clear cycle 200 forces data_out low and restarts a full clear
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (200) tick();
      check("t5_busy_mid", busy, 1'b1);
      check("t5_dout_pre", dout, 8'hC3);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_dout", dout, 8'h00);
      check("t5_async_busy", busy, 1'b1);
      repeat (2) tick();
      rst_n = 1'b1;
      count_busy(n);
      check("t5_busy_len", n, DEPTH);
      read_check("t5_rd_010", 9'h010, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
